// File: rtl/cgra_loader_pkg.sv
// cgra_loader_pkg: shared state type, default word geometry and last-word length helper
package cgra_loader_pkg;
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, DONE} loader_state_e;
   localparam int DW_DEFAULT = 32;
   localparam int WORD_BYTES = DW_DEFAULT / 8;
   function automatic int last_word_bits(input int bits, input int width);
      return (bits % width == 0) ? width : bits % width;
   endfunction
endpackage

// File: rtl/cgra_cfg_shifter.sv
// cgra_cfg_shifter: scan-chain shift register, stream bit counter and word-end detection
module cgra_cfg_shifter import cgra_loader_pkg::*; #(
   parameter int DATA_WIDTH     = DW_DEFAULT,
   parameter int BITSTREAM_BITS = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  shift_en,
   output logic                  bit_out,
   output logic                  last_word,
   output logic                  word_end
);
   localparam int CW = $clog2(BITSTREAM_BITS + 1);
   localparam int IW = $clog2(DATA_WIDTH + 1);
   localparam int LAST = last_word_bits(BITSTREAM_BITS, DATA_WIDTH);
   localparam logic [CW-1:0] LAST_START = CW'(BITSTREAM_BITS - LAST);
   localparam logic [IW-1:0] FULL_END = IW'(DATA_WIDTH - 1);
   localparam logic [IW-1:0] LAST_END = IW'(LAST - 1);
   logic [DATA_WIDTH-1:0] sreg;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   assign bit_out = sreg[0];
   // the final word is the only one with a short length, so word end there is stream end
   assign last_word = cnt >= LAST_START;
   assign word_end = shift_en && idx == (last_word ? LAST_END : FULL_END);
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         sreg <= '0;
         cnt <= '0;
         idx <= '0;
      end else if (clr) begin
         sreg <= '0;
         cnt <= '0;
         idx <= '0;
      end else begin
         if (shift_en) begin
            sreg <= sreg >> 1;
            cnt <= cnt + 1'b1;
            idx <= word_end ? '0 : idx + 1'b1;
         end
         if (load) begin
            sreg <= load_data;
            idx <= '0;
         end
      end
endmodule

// File: rtl/cgra_bitstream_loader.sv
// cgra_bitstream_loader: fetches the CGRA bitstream from RAM and shifts it LSB-first into the config chain; CGRA_LOADER_PREFETCH_EN adds a one-word prefetch buffer
module cgra_bitstream_loader import cgra_loader_pkg::*; #(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = DW_DEFAULT,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h8000,
   parameter int                    BITSTREAM_BITS = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cfg_reset_i,
   input  logic                  cfg_enable_i,
   output logic                  cfg_done_o,
   output logic                  data_req_o,
   output logic [ADDR_WIDTH-1:0] data_addr_o,
   input  logic                  data_gnt_i,
   input  logic                  data_rvalid_i,
   input  logic [DATA_WIDTH-1:0] data_rdata_i,
   output logic                  cfg_bit_o,
   output logic                  cfg_shift_o
);
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(WORD_BYTES * DATA_WIDTH / DW_DEFAULT);
   loader_state_e state, state_n;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] load_data;
   logic pending, hs, rsp, shift_en, load, bit_out, last_word, word_end;
   assign hs = data_req_o && data_gnt_i;
   // a response only counts against a request we still own; stale ones after a soft reset fall out here
   assign rsp = pending && data_rvalid_i;
   assign cfg_done_o = state == DONE;
   assign cfg_shift_o = shift_en;
   assign cfg_bit_o = shift_en && bit_out;
`ifdef CGRA_LOADER_PREFETCH_EN
   logic [DATA_WIDTH-1:0] pbuf;
   logic pfull;
   assign data_addr_o = (state == SHIFT) ? addr + STEP : addr;
`else
   assign data_addr_o = addr;
`endif
   always_comb begin
      state_n = state;
      data_req_o = 1'b0;
      load = 1'b0;
      load_data = data_rdata_i;
      shift_en = 1'b0;
      unique case (state)
         IDLE: state_n = cfg_enable_i ? FETCH : IDLE;
         FETCH: begin
            data_req_o = !pending;
            state_n = (!pending && data_gnt_i) ? WAIT : FETCH;
         end
         WAIT: begin
            load = rsp;
            state_n = rsp ? SHIFT : WAIT;
         end
         SHIFT: begin
            shift_en = cfg_enable_i;
`ifdef CGRA_LOADER_PREFETCH_EN
            data_req_o = !last_word && !pfull && !pending;
            if (word_end && !last_word) begin
               load = pfull || rsp;
               load_data = pfull ? pbuf : data_rdata_i;
               state_n = (pfull || rsp) ? SHIFT : (pending || (data_req_o && data_gnt_i)) ? WAIT : FETCH;
            end
`else
            if (word_end && !last_word) state_n = FETCH;
`endif
            if (word_end && last_word) state_n = DONE;
         end
         DONE: state_n = DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state <= IDLE;
         addr <= BASE_ADDR;
         pending <= 1'b0;
      end else begin
         pending <= hs ? 1'b1 : data_rvalid_i ? 1'b0 : pending;
         if (cfg_reset_i) begin
            state <= IDLE;
            addr <= BASE_ADDR;
         end else begin
            state <= state_n;
            if (word_end && !last_word) addr <= addr + STEP;
         end
      end
`ifdef CGRA_LOADER_PREFETCH_EN
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         pbuf <= '0;
         pfull <= 1'b0;
      end else if (cfg_reset_i) begin
         pfull <= 1'b0;
      end else if (load && pfull) begin
         pfull <= 1'b0;
      end else if (state == SHIFT && rsp && !load) begin
         pbuf <= data_rdata_i;
         pfull <= 1'b1;
      end
`endif
   cgra_cfg_shifter #(
      .DATA_WIDTH(DATA_WIDTH),
      .BITSTREAM_BITS(BITSTREAM_BITS)
   ) u_shifter (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .clr(cfg_reset_i),
      .load(load),
      .load_data(load_data),
      .shift_en(shift_en),
      .bit_out(bit_out),
      .last_word(last_word),
      .word_end(word_end)
   );
endmodule
